xt_lbus_master: RTL

XT_LBUS_MASTER -- requirements
Module: xt_lbus_master

---
 rtl/xt_lbus_pkg.sv | 35 +++
 rtl/xt_lbus_master.sv | 131 +++++++++++++
 2 files changed

// File: rtl/xt_lbus_pkg.sv
// Local-bus shared definitions: address split, slave count, width encodings
// and the broadcast bundle seen by every slave.
package xt_lbus_pkg;

    localparam int LB_ADDR_WIDTH   = 8;
    localparam int LB_ID_WIDTH     = 2;
    localparam int LB_OFFSET_WIDTH = LB_ADDR_WIDTH - LB_ID_WIDTH;
    localparam int LB_SLAVE_NUM    = 2 ** LB_ID_WIDTH;
    localparam int LB_DATA_WIDTH   = 32;

    localparam logic [1:0] LB_WIDTH_BYTE = 2'b00;
    localparam logic [1:0] LB_WIDTH_HALF = 2'b01;
    localparam logic [1:0] LB_WIDTH_WORD = 2'b10;
    localparam logic [1:0] LB_WIDTH_RSVD = 2'b11;

    typedef struct packed {
        logic [LB_OFFSET_WIDTH-1:0] addr;
        logic [1:0]                 write_width;
        logic [LB_DATA_WIDTH-1:0]   wdata;
    } lb_slave_t;

    // The slave ID occupies the top address bits, the offset the rest.
    function automatic logic [LB_ID_WIDTH-1:0] lb_get_id(input logic [LB_ADDR_WIDTH-1:0] addr);
        return addr[LB_ADDR_WIDTH-1 -: LB_ID_WIDTH];
    endfunction

    function automatic logic [LB_OFFSET_WIDTH-1:0] lb_get_offset(input logic [LB_ADDR_WIDTH-1:0] addr);
        return addr[LB_OFFSET_WIDTH-1:0];
    endfunction

    function automatic logic [LB_SLAVE_NUM-1:0] lb_onehot(input logic [LB_ID_WIDTH-1:0] id);
        return LB_SLAVE_NUM'(1) << id;
    endfunction

endpackage

// File: rtl/xt_lbus_master.sv
// Single-outstanding local-bus master: turns one core request into a one-cycle
// slave strobe, waits for that slave's ack (or times out) and returns a response.
module xt_lbus_master
    import xt_lbus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        req_valid,
    output logic                                        req_ready,
    input  logic [LB_ADDR_WIDTH-1:0]                    req_addr,
    input  logic                                        req_we,
    input  logic [1:0]                                  req_width,
    input  logic [LB_DATA_WIDTH-1:0]                    req_wdata,
    output logic                                        rsp_valid,
    output logic [LB_DATA_WIDTH-1:0]                    rsp_rdata,
    output logic                                        rsp_err,
    output lb_slave_t                                   lb_slave,
    output logic [LB_SLAVE_NUM-1:0]                     lb_wen,
    output logic [LB_SLAVE_NUM-1:0]                     lb_ren,
    input  logic [LB_SLAVE_NUM-1:0][LB_DATA_WIDTH-1:0]  lb_rdata,
    input  logic [LB_SLAVE_NUM-1:0]                     lb_ack
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Counter holds the index of the current WAIT cycle, so the last one is T-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                   state_r;
    logic [LB_ID_WIDTH-1:0]   id_r;
    logic                     we_r;
    logic [CNT_W-1:0]         cnt_r;
    logic                     ack_sel_s;
    logic [LB_DATA_WIDTH-1:0] rdata_sel_s;

    assign ack_sel_s   = lb_ack[id_r];
    assign rdata_sel_s = lb_rdata[id_r];

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            id_r      <= '0;
            we_r      <= 1'b0;
            cnt_r     <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            lb_slave  <= '0;
            lb_wen    <= '0;
            lb_ren    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        id_r      <= lb_get_id(req_addr);
                        we_r      <= req_we;
                        cnt_r     <= '0;
                        if (req_width == LB_WIDTH_RSVD) begin
                            state_r   <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state_r              <= ST_ISSUE;
                            lb_slave.addr        <= lb_get_offset(req_addr);
                            lb_slave.write_width <= req_width;
                            lb_slave.wdata       <= req_wdata;
                            if (req_we) begin
                                lb_wen <= lb_onehot(lb_get_id(req_addr));
                            end else begin
                                lb_ren <= lb_onehot(lb_get_id(req_addr));
                            end
                        end
                    end
                end
                ST_ISSUE: begin
                    lb_wen <= '0;
                    lb_ren <= '0;
                    if (ack_sel_s) begin
                        state_r   <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= we_r ? '0 : rdata_sel_s;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Ack is checked first so a late ack beats the timeout.
                    if (ack_sel_s) begin
                        state_r   <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= we_r ? '0 : rdata_sel_s;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r   <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state_r   <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    lb_wen    <= '0;
                    lb_ren    <= '0;
                end
            endcase
        end
    end

endmodule
